// File: rtl/micro_sequencer.sv
// Microprogrammed control sequencer: micro-PC, microcode ROM, two dispatch ROMs, optional return
// stack. Define MSEQ_STACK_EN to build the CALL/RET return stack and its sticky error flags.
module micro_sequencer #(
   parameter int unsigned UADDR_W     = 6,
   parameter int unsigned CW_W        = 16,
   parameter int unsigned KEY_W       = 6,
   parameter int unsigned NCOND       = 4,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned RESET_UADDR = 0,
   // Flattened ROM images; entry i lives at [i*W +: W]. Microword = {ctrl, seq, csel, target}.
   parameter logic [(2**UADDR_W)*(CW_W+3+((NCOND > 1) ? $clog2(NCOND) : 1)+UADDR_W)-1:0]
      UCODE_IMG = '0,
   parameter logic [(2**KEY_W)*UADDR_W-1:0] DISP0_IMG = '0,
   parameter logic [(2**KEY_W)*UADDR_W-1:0] DISP1_IMG = '0
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 stall_i,
   input  logic [KEY_W-1:0]                     dispatch_key_i,
   input  logic [NCOND-1:0]                     cond_i,
   output logic [CW_W-1:0]                      ctrl_o,
   output logic [UADDR_W-1:0]                   upc_o,
   output logic [$clog2(STACK_DEPTH+1)-1:0]     sp_o,
   output logic                                 stk_ovf_o,
   output logic                                 stk_unf_o
);

   localparam int unsigned CSEL_W  = (NCOND > 1) ? $clog2(NCOND) : 1;
   localparam int unsigned UWORD_W = CW_W + 3 + CSEL_W + UADDR_W;
   localparam int unsigned CPAD_W  = 2**CSEL_W;
   localparam logic [UADDR_W-1:0] RST_UADDR = UADDR_W'(RESET_UADDR);

   typedef enum logic [2:0] {
      SeqNext, SeqJump, SeqDisp0, SeqDisp1, SeqCbr, SeqCall, SeqRet, SeqFetch
   } seq_e;

   logic [UADDR_W-1:0] upc_q, upc_d, upc_inc;
   logic [UWORD_W-1:0] uword;
   logic [CW_W-1:0]    uw_ctrl;
   logic [2:0]         uw_seq_raw;
   seq_e               uw_seq;
   logic [CSEL_W-1:0]  uw_csel;
   logic [UADDR_W-1:0] uw_target;
   logic [CPAD_W-1:0]  cond_pad;
   logic               cond_hit;
   logic [UADDR_W-1:0] disp0_addr, disp1_addr;

   assign uword = UCODE_IMG[upc_q*UWORD_W +: UWORD_W];
   assign {uw_ctrl, uw_seq_raw, uw_csel, uw_target} = uword;
   assign uw_seq     = seq_e'(uw_seq_raw);
   assign upc_inc    = upc_q + UADDR_W'(1);
   assign disp0_addr = DISP0_IMG[dispatch_key_i*UADDR_W +: UADDR_W];
   assign disp1_addr = DISP1_IMG[dispatch_key_i*UADDR_W +: UADDR_W];

   // Selects beyond NCOND read as 0 via zero padding.
   always_comb begin
      cond_pad = '0;
      cond_pad[NCOND-1:0] = cond_i;
   end
   assign cond_hit = cond_pad[uw_csel];

   assign ctrl_o = stall_i ? '0 : uw_ctrl;
   assign upc_o  = upc_q;

`ifdef MSEQ_STACK_EN
   localparam int unsigned SP_W    = $clog2(STACK_DEPTH + 1);
   localparam int unsigned STKIX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [UADDR_W-1:0] stack_q [STACK_DEPTH];
   logic [SP_W-1:0]    sp_q, sp_d;
   logic               ovf_q, ovf_d, unf_q, unf_d;
   logic               push;
   logic [STKIX_W-1:0] push_idx, pop_idx;

   assign push_idx = STKIX_W'(sp_q);
   assign pop_idx  = STKIX_W'(sp_q - SP_W'(1));

   always_comb begin
      upc_d = upc_q;
      sp_d  = sp_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      push  = 1'b0;
      if (!stall_i) begin
         unique case (uw_seq)
            SeqNext:  upc_d = upc_inc;
            SeqJump:  upc_d = uw_target;
            SeqDisp0: upc_d = disp0_addr;
            SeqDisp1: upc_d = disp1_addr;
            SeqCbr:   upc_d = cond_hit ? uw_target : upc_inc;
            SeqCall: begin
               upc_d = uw_target;
               if (sp_q == SP_W'(STACK_DEPTH)) begin
                  ovf_d = 1'b1;
               end else begin
                  push = 1'b1;
                  sp_d = sp_q + SP_W'(1);
               end
            end
            SeqRet: begin
               if (sp_q == '0) begin
                  upc_d = RST_UADDR;
                  unf_d = 1'b1;
               end else begin
                  upc_d = stack_q[pop_idx];
                  sp_d  = sp_q - SP_W'(1);
               end
            end
            SeqFetch: upc_d = RST_UADDR;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         upc_q <= RST_UADDR;
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         upc_q <= upc_d;
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Stack contents are don't-care after reset, so no reset term here.
   always_ff @(posedge clk_i) begin
      if (push) begin
         stack_q[push_idx] <= upc_inc;
      end
   end

   assign sp_o      = sp_q;
   assign stk_ovf_o = ovf_q;
   assign stk_unf_o = unf_q;
`else
   always_comb begin
      upc_d = upc_q;
      if (!stall_i) begin
         unique case (uw_seq)
            SeqNext:  upc_d = upc_inc;
            SeqJump:  upc_d = uw_target;
            SeqDisp0: upc_d = disp0_addr;
            SeqDisp1: upc_d = disp1_addr;
            SeqCbr:   upc_d = cond_hit ? uw_target : upc_inc;
            SeqCall:  upc_d = uw_target;
            SeqRet:   upc_d = RST_UADDR;
            SeqFetch: upc_d = RST_UADDR;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         upc_q <= RST_UADDR;
      end else begin
         upc_q <= upc_d;
      end
   end

   assign sp_o      = '0;
   assign stk_ovf_o = 1'b0;
   assign stk_unf_o = 1'b0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: builds a small microprogram and checks upc/sp/flags/ctrl.
// Expectations follow MSEQ_STACK_EN so the bench suits either build.
module tb_micro_sequencer;

   localparam int UW = 16 + 3 + 2 + 6;

`ifdef MSEQ_STACK_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   function automatic logic [15:0] ctrl_of(input int a);
      return 16'h5A00 | 16'(a);
   endfunction

   // seq: 0 NEXT 1 JUMP 2 DISP0 3 DISP1 4 CBR 5 CALL 6 RET 7 FETCH
   function automatic logic [UW-1:0] uword_of(input int a);
      logic [2:0] s;
      logic [1:0] c;
      logic [5:0] t;
      s = 3'd0;
      c = 2'd0;
      t = 6'd0;
      case (a)
         'h01: s = 3'd2;
         'h20: begin s = 3'd4; c = 2'd2; t = 6'h30; end
         'h21: s = 3'd7;
         'h30: s = 3'd3;
         'h24: begin s = 3'd1; t = 6'h05; end
         'h05: begin s = 3'd5; t = 6'h10; end
         'h06: begin s = 3'd1; t = 6'h38; end
         'h11: s = 3'd6;
         'h38: begin s = 3'd5; t = 6'h38; end
         'h3A: s = 3'd6;
         default: ;
      endcase
      return {ctrl_of(a), s, c, t};
   endfunction

   function automatic logic [64*UW-1:0] build_ucode();
      logic [64*UW-1:0] img;
      img = '0;
      for (int a = 0; a < 64; a++) img[a*UW +: UW] = uword_of(a);
      return img;
   endfunction

   function automatic logic [64*6-1:0] build_disp0();
      logic [64*6-1:0] img;
      img = '0;
      img[8'h12*6 +: 6] = 6'h20;
      img[8'h15*6 +: 6] = 6'h38;
      img[8'h05*6 +: 6] = 6'h3A;
      img[8'h07*6 +: 6] = 6'h3F;
      return img;
   endfunction

   function automatic logic [64*6-1:0] build_disp1();
      logic [64*6-1:0] img;
      img = '0;
      img[8'h12*6 +: 6] = 6'h24;
      return img;
   endfunction

   localparam logic [64*UW-1:0] UCODE = build_ucode();
   localparam logic [64*6-1:0]  DISP0 = build_disp0();
   localparam logic [64*6-1:0]  DISP1 = build_disp1();

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic [5:0]  key;
   logic [3:0]  cond;
   logic [15:0] ctrl;
   logic [5:0]  upc;
   logic [2:0]  sp;
   logic        ovf, unf;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   micro_sequencer #(
      .UADDR_W    (6),
      .CW_W       (16),
      .KEY_W      (6),
      .NCOND      (4),
      .STACK_DEPTH(4),
      .RESET_UADDR(0),
      .UCODE_IMG  (UCODE),
      .DISP0_IMG  (DISP0),
      .DISP1_IMG  (DISP1)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .stall_i       (stall),
      .dispatch_key_i(key),
      .cond_i        (cond),
      .ctrl_o        (ctrl),
      .upc_o         (upc),
      .sp_o          (sp),
      .stk_ovf_o     (ovf),
      .stk_unf_o     (unf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic chk_state(input string tag, input int e_upc, input int e_sp,
                            input bit e_ovf, input bit e_unf);
      check({tag, ".upc"}, 32'(upc), 32'(e_upc));
      check({tag, ".sp"},  32'(sp),  32'(e_sp));
      check({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
      check({tag, ".unf"}, 32'(unf), 32'(e_unf));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      stall = 1'b0;
      key   = 6'h12;
      cond  = 4'b0100;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      step();
      check("run.upc", 32'(upc), 32'h20);

      // Async reset mid-program, held three cycles.
      rst_n = 1'b0;
      #1;
      chk_state("rst_async", 0, 0, 1'b0, 1'b0);
      repeat (3) step();
      rst_n = 1'b1;
      check("rst.ctrl", 32'(ctrl), 32'(ctrl_of(0)));
      chk_state("rst_rel", 0, 0, 1'b0, 1'b0);

      step();
      check("next.upc", 32'(upc), 32'h01);
      check("next.ctrl", 32'(ctrl), 32'(ctrl_of(1)));
      step();
      check("disp0.upc", 32'(upc), 32'h20);
      step();
      check("cbr_taken.upc", 32'(upc), 32'h30);
      step();
      check("disp1.upc", 32'(upc), 32'h24);
      step();
      check("jump.upc", 32'(upc), 32'h05);

      // Stall on the CALL: everything frozen, control word gated.
      stall = 1'b1;
      #1;
      check("stall.ctrl", 32'(ctrl), 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("stall_hold.upc", 32'(upc), 32'h05);
         check("stall_hold.sp", 32'(sp), 32'h0);
         check("stall_hold.ctrl", 32'(ctrl), 32'h0);
      end
      stall = 1'b0;
      #1;
      check("unstall.ctrl", 32'(ctrl), 32'(ctrl_of(5)));
      step();
      chk_state("call", 'h10, STK ? 1 : 0, 1'b0, 1'b0);
      step();
      chk_state("sub", 'h11, STK ? 1 : 0, 1'b0, 1'b0);
      step();
      chk_state("ret", STK ? 'h06 : 'h00, 0, 1'b0, 1'b0);

      // Nested self-CALLs: four push, the fifth overflows.
      rst_pulse();
      key = 6'h15;
      step();
      step();
      check("nest_entry.upc", 32'(upc), 32'h38);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk_state("nest", 'h38, STK ? i : 0, 1'b0, 1'b0);
      end
      step();
      chk_state("nest_ovf", 'h38, STK ? 4 : 0, STK, 1'b0);
      step();
      check("ovf_sticky", 32'(ovf), 32'(STK));

      // Reset while deep in a subroutine.
      rst_n = 1'b0;
      #1;
      chk_state("rst_mid_sub", 0, 0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // RET with empty stack.
      key = 6'h05;
      step();
      step();
      check("unf_entry.upc", 32'(upc), 32'h3A);
      step();
      chk_state("ret_unf", 0, 0, 1'b0, STK);
      repeat (3) step();
      chk_state("unf_sticky", 0, 0, 1'b0, STK);

      // upc wraps from the top address to 0.
      rst_pulse();
      key = 6'h07;
      step();
      step();
      check("wrap_entry.upc", 32'(upc), 32'h3F);
      check("wrap_entry.unf", 32'(unf), 32'h0);
      step();
      check("wrap.upc", 32'(upc), 32'h00);

      // CBR not taken: cond[2] low, other flags high.
      rst_pulse();
      key  = 6'h12;
      cond = 4'b1011;
      step();
      step();
      step();
      check("cbr_nt.upc", 32'(upc), 32'h21);
      step();
      check("fetch.upc", 32'(upc), 32'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
